// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: turns one single-port READ_FIRST BRAM into a synchronous FIFO.
// Push and pop share the BRAM port, one op per cycle, with an alternating
// priority under contention. A 2-entry output buffer hides the 1-cycle read
// latency so the head word is always registered on m_data.
module bram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam logic [ADDR_WIDTH:0] MEM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic                  prio_rd_q, prio_rd_d;
  // Holds s_ready low during reset and for the first cycle after release.
  logic                  ready_en_q;

  logic rd_elig;
  logic grant_wr;
  logic grant_rd;
  logic contend;
  logic pop;

  // Port arbitration and status flags, all derived from registered state.
  always_comb begin
    full      = (mem_cnt_q == MEM_FULL);
    rd_elig   = (mem_cnt_q != '0) && ((ob_cnt_q + {1'b0, rd_inflight_q}) < 2'd2);
    s_ready   = ready_en_q && !full && (!rd_elig || !prio_rd_q);
    grant_wr  = s_valid && s_ready;
    grant_rd  = rd_elig && !grant_wr;
    contend   = s_valid && ready_en_q && !full && rd_elig;
    bram_we   = grant_wr;
    bram_addr = grant_wr ? wr_ptr_q : rd_ptr_q;
    bram_din  = s_data;
    m_valid   = (ob_cnt_q != 2'd0);
    m_data    = ob0_q;
    pop       = m_valid && m_ready;
    count     = {1'b0, mem_cnt_q}
              + {{(ADDR_WIDTH+1){1'b0}}, rd_inflight_q}
              + {{ADDR_WIDTH{1'b0}}, ob_cnt_q};
    empty     = (count == '0);
  end

  // Next-state for pointers, occupancy, priority and the output buffer.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = grant_rd;
    prio_rd_d     = prio_rd_q;
    ob0_d         = ob0_q;
    ob1_d         = ob1_q;
    ob_cnt_d      = ob_cnt_q;

    if (grant_wr) begin
      wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
      mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
    end else if (grant_rd) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      mem_cnt_d = mem_cnt_q - (ADDR_WIDTH+1)'(1);
    end

    if (contend) begin
      prio_rd_d = !prio_rd_q;
    end

    // ob0 is always the head; a pop shifts ob1 down, a capture fills the
    // first free slot after any shift, so order holds when both coincide.
    case ({pop, rd_inflight_q})
      2'b10: begin
        ob0_d    = ob1_q;
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b01: begin
        if (ob_cnt_q == 2'd0) ob0_d = bram_dout;
        else                  ob1_d = bram_dout;
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob0_d = bram_dout;
        end else begin
          ob0_d = ob1_q;
          ob1_d = bram_dout;
        end
      end
      default: ;
    endcase
  end

  // State registers; an in-flight read is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      ob0_q         <= '0;
      ob1_q         <= '0;
      ob_cnt_q      <= '0;
      prio_rd_q     <= 1'b1;
      ready_en_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob0_q         <= ob0_d;
      ob1_q         <= ob1_d;
      ob_cnt_q      <= ob_cnt_d;
      prio_rd_q     <= prio_rd_d;
      ready_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a READ_FIRST BRAM model.
module tb_bram_fifo_ctrl;

  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] count;
  logic          full;
  logic          empty;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Single-port READ_FIRST BRAM, registered read.
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .bram_we  (bram_we),
    .bram_addr(bram_addr),
    .bram_din (bram_din),
    .bram_dout(bram_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input int budget, output bit ok);
    s_data  = d;
    s_valid = 1'b1;
    ok      = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic pop_expect(input logic [DW-1:0] exp, input int budget, input string tag);
    bit found;
    found   = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (m_valid) begin
        check(tag, m_data, exp);
        found = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    if (!found) check({tag, "_timeout"}, found, 1);
  endtask

  function automatic logic [DW-1:0] pat4(input int i);
    return 16'(i * 7 + 3);
  endfunction

  initial begin
    bit ok;
    int n_acc;
    int wr_i;
    int rd_i;
    int cyc;
    bit acc;
    bit prev_acc;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // 1: reset state and release
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_count",   count,   0);
    check("rst_empty",   empty,   1);
    check("rst_full",    full,    0);
    check("rst_m_data",  m_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready_low", s_ready, 0);
    @(posedge clk);
    #1;
    check("rel_s_ready_high", s_ready, 1);

    // 2: single push, latency of 2 edges
    push(16'hA5A5, 4, ok);
    check("t2_acc", ok, 1);
    @(negedge clk);
    check("t2_mv_e0", m_valid, 0);
    @(negedge clk);
    check("t2_mv_e1", m_valid, 0);
    @(negedge clk);
    check("t2_mv_e2", m_valid, 1);
    check("t2_data",  m_data, 16'hA5A5);
    check("t2_count", count, 1);
    check("t2_empty", empty, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("t2_pop_empty", empty, 1);
    check("t2_pop_mv",    m_valid, 0);

    // 3: fill to capacity, then drain in order
    n_acc = 0;
    for (int v = 0; v <= 600; v++) begin
      push(16'(v), 4, ok);
      if (!ok) break;
      n_acc++;
    end
    check("t3_accepted", n_acc, 514);
    check("t3_full",     full, 1);
    check("t3_count",    count, 514);
    check("t3_s_ready",  s_ready, 0);
    for (int v = 0; v < 514; v++) begin
      pop_expect(16'(v), 6, "t3_pop");
    end
    check("t3_empty", empty, 1);
    check("t3_full_clr", full, 0);

    // 4: continuous push and pop, alternating grants, pointer wraps
    wr_i = 0;
    rd_i = 0;
    cyc  = 0;
    prev_acc = 1'b0;
    while (rd_i < 2000 && cyc < 6000) begin
      s_valid = (wr_i < 2000);
      s_data  = pat4(wr_i);
      m_ready = 1'b1;
      @(negedge clk);
      acc = s_valid && s_ready;
      check("t4_we", bram_we, acc);
      check("t4_count", count, 32'(wr_i - rd_i));
      if (m_valid) begin
        check("t4_data", m_data, pat4(rd_i));
        rd_i++;
      end
      if (cyc >= 10 && wr_i < 2000) check("t4_alt", acc, !prev_acc);
      prev_acc = acc;
      if (acc) wr_i++;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("t4_popped", rd_i, 2000);
    check("t4_empty", empty, 1);

    // 5: ten words, random pop pattern
    for (int v = 0; v < 10; v++) begin
      push(16'hC000 + 16'(v), 4, ok);
      check("t5_push", ok, 1);
    end
    repeat (6) @(posedge clk);
    #1;
    check("t5_count10", count, 10);
    check("t5_mv", m_valid, 1);
    rd_i = 0;
    cyc  = 0;
    while (rd_i < 10 && cyc < 300) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = m_valid && m_ready;
      if (m_valid) check("t5_data", m_data, 16'hC000 + 16'(rd_i));
      @(posedge clk);
      #1;
      if (acc) rd_i++;
      check("t5_count", count, 32'(10 - rd_i));
      cyc++;
    end
    m_ready = 1'b0;
    check("t5_popped", rd_i, 10);
    check("t5_empty", empty, 1);

    // 6: reset mid-stream, then clean restart
    for (int v = 0; v < 3; v++) begin
      push(16'h0D00 + 16'(v), 4, ok);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_m_valid", m_valid, 0);
    check("t6_m_data",  m_data,  0);
    check("t6_s_ready", s_ready, 0);
    check("t6_bram_we", bram_we, 0);
    check("t6_count",   count,   0);
    check("t6_empty",   empty,   1);
    check("t6_full",    full,    0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_rel_low", s_ready, 0);
    @(posedge clk);
    #1;
    check("t6_rel_high", s_ready, 1);
    check("t6_rel_mv",   m_valid, 0);
    push(16'h0001, 4, ok);
    check("t6_push1", ok, 1);
    push(16'h0002, 4, ok);
    check("t6_push2", ok, 1);
    pop_expect(16'h0001, 6, "t6_pop1");
    pop_expect(16'h0002, 6, "t6_pop2");
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_stale", m_valid, 0);
    check("t6_count_end", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
